// File: rtl/nvdla_dbb_rd_bridge.sv
// NVDLA DBB read-channel to HWPE TCDM bridge: one burst at a time, one TCDM word read per beat.
// Define NVDLA_DBB_RD_PERF_EN to build the rsp back-pressure stall counter on perf_stall_cnt_o.
module nvdla_dbb_rd_bridge #(
  parameter int unsigned RSP_FIFO_DEPTH = 4,
  parameter int unsigned ID_WIDTH       = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                rd_req_valid_i,
  output logic                rd_req_ready_o,
  input  logic [31:0]         rd_req_addr_i,
  input  logic [3:0]          rd_req_len_i,
  input  logic [ID_WIDTH-1:0] rd_req_id_i,
  output logic                tcdm_req_o,
  input  logic                tcdm_gnt_i,
  output logic [31:0]         tcdm_add_o,
  input  logic                tcdm_r_valid_i,
  input  logic [31:0]         tcdm_r_data_i,
  output logic                rd_rsp_valid_o,
  input  logic                rd_rsp_ready_i,
  output logic [31:0]         rd_rsp_data_o,
  output logic                rd_rsp_last_o,
  output logic [ID_WIDTH-1:0] rd_rsp_id_o,
  output logic                busy_o,
  output logic [31:0]         perf_stall_cnt_o
);

  localparam int unsigned PtrW = $clog2(RSP_FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e              r_state, w_state_d;
  logic [31:0]         r_base;
  logic [3:0]          r_len;
  logic [ID_WIDTH-1:0] r_id;
  logic [4:0]          r_issue_cnt;
  logic [3:0]          r_pop_cnt;
  logic [CntW-1:0]     r_outstanding;
  logic [CntW-1:0]     r_count;
  logic [PtrW-1:0]     r_wptr;
  logic [PtrW-1:0]     r_rptr;
  logic [31:0]         r_mem [RSP_FIFO_DEPTH];

  logic [CntW:0]       w_used;
  logic                w_req;
  logic                w_grant;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_last;
  logic                w_ready;
  logic                w_accept;

  // Credit = free FIFO slots not already promised to an in-flight read.
  assign w_used   = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req    = (r_state == StIssue) && (w_used < (CntW + 1)'(RSP_FIFO_DEPTH));
  assign w_grant  = w_req && tcdm_gnt_i;
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CntW'(RSP_FIFO_DEPTH));
  // Responses seen in IDLE belong to a cleared burst and are discarded.
  assign w_push   = tcdm_r_valid_i && (r_state != StIdle) && !clear_i;
  assign w_pop    = !w_empty && rd_rsp_ready_i && !clear_i;
  assign w_last   = (r_pop_cnt == r_len);
  assign w_ready  = (r_state == StIdle) && (r_outstanding == '0) && !clear_i && !rst_i;
  assign w_accept = rd_req_valid_i && w_ready;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = StIssue;
      StIssue: if (w_grant && (r_issue_cnt == {1'b0, r_len})) w_state_d = StDrain;
      StDrain: if (w_pop && w_last) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (clear_i) w_state_d = StIdle;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_base  <= '0;
      r_len   <= '0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_base <= rd_req_addr_i & ~32'h3;
        r_len  <= rd_req_len_i;
        r_id   <= rd_req_id_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_issue_cnt <= '0;
      r_pop_cnt   <= '0;
    end else if (clear_i || w_accept) begin
      r_issue_cnt <= '0;
      r_pop_cnt   <= '0;
    end else begin
      if (w_grant) r_issue_cnt <= r_issue_cnt + 5'd1;
      if (w_pop)   r_pop_cnt   <= r_pop_cnt + 4'd1;
    end
  end

  // Outstanding survives clear so late responses can still be counted off.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
    end else begin
      unique case ({w_grant, tcdm_r_valid_i})
        2'b10:   r_outstanding <= r_outstanding + CntW'(1);
        2'b01:   r_outstanding <= r_outstanding - CntW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < RSP_FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (clear_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= tcdm_r_data_i;
        r_wptr        <= r_wptr + PtrW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PtrW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_req_ready_o = w_ready;
  assign tcdm_req_o     = w_req;
  assign tcdm_add_o     = r_base + (32'(r_issue_cnt) << 2);
  assign rd_rsp_valid_o = !w_empty;
  assign rd_rsp_data_o  = w_empty ? 32'h0 : r_mem[r_rptr];
  assign rd_rsp_last_o  = !w_empty && w_last;
  assign rd_rsp_id_o    = r_id;
  assign busy_o         = (r_state != StIdle) || (r_outstanding != '0);

`ifdef NVDLA_DBB_RD_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (clear_i) begin
      r_stall_cnt <= '0;
    end else if (!w_empty && !rd_rsp_ready_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt_o = r_stall_cnt;
`else
  assign perf_stall_cnt_o = 32'h0;
`endif

  // Credit accounting must keep a response from ever landing on a full FIFO.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(tcdm_r_valid_i && w_full))
    else $error("response pushed into full FIFO");

endmodule

// File: tb/tb_nvdla_dbb_rd_bridge.sv
// Bench for nvdla_dbb_rd_bridge: TCDM memory model, burst vector table and scoreboard,
// plus hand sequences for back-pressure, clear and async reset.
module tb_nvdla_dbb_rd_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clear_i;
  logic        rd_req_valid_i;
  logic        rd_req_ready_o;
  logic [31:0] rd_req_addr_i;
  logic [3:0]  rd_req_len_i;
  logic [7:0]  rd_req_id_i;
  logic        tcdm_req_o;
  logic        tcdm_gnt_i;
  logic [31:0] tcdm_add_o;
  logic        tcdm_r_valid_i;
  logic [31:0] tcdm_r_data_i;
  logic        rd_rsp_valid_o;
  logic        rd_rsp_ready_i;
  logic [31:0] rd_rsp_data_o;
  logic        rd_rsp_last_o;
  logic [7:0]  rd_rsp_id_o;
  logic        busy_o;
  logic [31:0] perf_stall_cnt_o;

  nvdla_dbb_rd_bridge #(
    .RSP_FIFO_DEPTH(4),
    .ID_WIDTH      (8)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .clear_i         (clear_i),
    .rd_req_valid_i  (rd_req_valid_i),
    .rd_req_ready_o  (rd_req_ready_o),
    .rd_req_addr_i   (rd_req_addr_i),
    .rd_req_len_i    (rd_req_len_i),
    .rd_req_id_i     (rd_req_id_i),
    .tcdm_req_o      (tcdm_req_o),
    .tcdm_gnt_i      (tcdm_gnt_i),
    .tcdm_add_o      (tcdm_add_o),
    .tcdm_r_valid_i  (tcdm_r_valid_i),
    .tcdm_r_data_i   (tcdm_r_data_i),
    .rd_rsp_valid_o  (rd_rsp_valid_o),
    .rd_rsp_ready_i  (rd_rsp_ready_i),
    .rd_rsp_data_o   (rd_rsp_data_o),
    .rd_rsp_last_o   (rd_rsp_last_o),
    .rd_rsp_id_o     (rd_rsp_id_o),
    .busy_o          (busy_o),
    .perf_stall_cnt_o(perf_stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [7:0]  id;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [7:0]  id;
    int          rdy;
    bit          gnt_rand;
    int          lat;
    int          beats;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;

  beat_t       exp_q[$];
  logic [31:0] addr_q[$];
  rsp_t        rq[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          gnt_budget = -1;
  bit          gnt_rand = 1'b0;
  int          rdy_mode = 0;
  bit          hold_rsp = 1'b0;
  bit          clear_pulse = 1'b0;
  bit          req_pending = 1'b0;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [7:0]  req_id;
  int          n_grants, n_pops, occ, max_occ;
  logic [31:0] first_add, last_add;
  logic [31:0] stall_cnt = '0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1 ^ (a << 3);
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endfunction

  function automatic void fail(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s", name, what);
  endfunction

  function automatic void check_perf(input string name);
`ifdef NVDLA_DBB_RD_PERF_EN
    check(name, perf_stall_cnt_o, stall_cnt);
`else
    check(name, perf_stall_cnt_o, 32'h0);
`endif
  endfunction

  task automatic start_burst(input logic [31:0] a, input logic [3:0] l, input logic [7:0] id);
    req_pending = 1'b1;
    req_addr    = a;
    req_len     = l;
    req_id      = id;
    n_grants    = 0;
    n_pops      = 0;
  endtask

  // One clock: drive inputs just after negedge, then observe what the next posedge will commit.
  task automatic cycle();
    logic [31:0] base;
    logic [31:0] a;
    beat_t       b;
    @(negedge clk_i);
    cyc++;
    if (!hold_rsp && rq.size() > 0 && rq[0].due <= cyc) begin
      tcdm_r_valid_i = 1'b1;
      tcdm_r_data_i  = rq[0].data;
      rq.delete(0);
    end else begin
      tcdm_r_valid_i = 1'b0;
      tcdm_r_data_i  = '0;
    end
    tcdm_gnt_i = (gnt_budget != 0) && (!gnt_rand || ($urandom_range(0, 1) == 1));
    case (rdy_mode)
      0:       rd_rsp_ready_i = 1'b1;
      1:       rd_rsp_ready_i = 1'b0;
      2:       rd_rsp_ready_i = cyc[0];
      default: rd_rsp_ready_i = ($urandom_range(0, 1) == 1);
    endcase
    clear_i        = clear_pulse;
    clear_pulse    = 1'b0;
    rd_req_valid_i = req_pending;
    rd_req_addr_i  = req_addr;
    rd_req_len_i   = req_len;
    rd_req_id_i    = req_id;
    #1;
    if (tcdm_req_o && tcdm_gnt_i) begin
      if (addr_q.size() == 0) fail("tcdm_grant", "grant with no beat expected");
      else check("tcdm_add", tcdm_add_o, addr_q.pop_front());
      if (n_grants == 0) first_add = tcdm_add_o;
      last_add = tcdm_add_o;
      n_grants++;
      occ++;
      rq.push_back('{data: mem(tcdm_add_o), due: cyc + lat});
      if (gnt_budget > 0) gnt_budget--;
    end
    if (rd_rsp_valid_o && rd_rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        fail("rsp_beat", "beat delivered with none expected");
      end else begin
        b = exp_q.pop_front();
        check("rsp_data", rd_rsp_data_o, b.data);
        check("rsp_last", 32'(rd_rsp_last_o), 32'(b.last));
        check("rsp_id", 32'(rd_rsp_id_o), 32'(b.id));
      end
      n_pops++;
      occ--;
    end
    if (rd_rsp_valid_o && !rd_rsp_ready_i) stall_cnt++;
    if (rd_req_valid_i && rd_req_ready_o) begin
      req_pending = 1'b0;
      base = req_addr & ~32'h3;
      for (int i = 0; i <= int'(req_len); i++) begin
        a = base + 32'(4 * i);
        addr_q.push_back(a);
        exp_q.push_back('{data: mem(a), last: (i == int'(req_len)), id: req_id});
      end
    end
    if (clear_i) begin
      exp_q.delete();
      addr_q.delete();
      stall_cnt = '0;
    end
    if (occ > max_occ) max_occ = occ;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while ((req_pending || exp_q.size() != 0 || busy_o) && k < budget) begin
      cycle();
      k++;
    end
    if (k >= budget) fail(name, "timed out waiting for burst to complete");
  endtask

  task automatic wait_grants(input int n, input int budget, input string name);
    int k = 0;
    while (n_grants < n && k < budget) begin
      cycle();
      k++;
    end
    if (k >= budget) fail(name, "timed out waiting for grants");
  endtask

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_1000, 4'd0,  8'h5A, 0, 1'b0, 1, 1,  32'h0000_1000, 32'h0000_1000};
    vecs[1] = '{32'h0000_2000, 4'd15, 8'hC3, 2, 1'b0, 1, 16, 32'h0000_2000, 32'h0000_203C};
    vecs[2] = '{32'hFFFF_FFFE, 4'd2,  8'h11, 0, 1'b0, 1, 3,  32'hFFFF_FFFC, 32'h0000_0004};
    vecs[3] = '{32'h0000_4003, 4'd7,  8'h7E, 2, 1'b0, 1, 8,  32'h0000_4000, 32'h0000_401C};
    vecs[4] = '{32'h0000_0010, 4'd5,  8'hFF, 3, 1'b1, 3, 6,  32'h0000_0010, 32'h0000_0024};

    rst_i = 1'b1; clear_i = 1'b0; rd_req_valid_i = 1'b0; rd_req_addr_i = '0;
    rd_req_len_i = '0; rd_req_id_i = '0; tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b0;
    tcdm_r_data_i = '0; rd_rsp_ready_i = 1'b0;
    #12;
    check("reset_req_ready", 32'(rd_req_ready_o), 32'h0);
    check("reset_tcdm_req", 32'(tcdm_req_o), 32'h0);
    check("reset_rsp_valid", 32'(rd_rsp_valid_o), 32'h0);
    check("reset_busy", 32'(busy_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("post_reset_req_ready", 32'(rd_req_ready_o), 32'h1);

    // Full burst with rsp back-pressure: only FIFO-depth grants may go out.
    rdy_mode = 1; gnt_rand = 1'b0; gnt_budget = -1; lat = 1;
    start_burst(32'h0000_2000, 4'd15, 8'h2A);
    repeat (20) cycle();
    check("bp_grants", 32'(n_grants), 32'd4);
    check("bp_tcdm_req_low", 32'(tcdm_req_o), 32'h0);
    check("bp_rsp_valid", 32'(rd_rsp_valid_o), 32'h1);
    check_perf("bp_perf_stalled");
    rdy_mode = 0;
    wait_done(200, "bp_done");
    check("bp_beats", 32'(n_pops), 32'd16);
    check_perf("bp_perf_hold");

    for (int v = 0; v < 5; v++) begin
      rdy_mode = vecs[v].rdy; gnt_rand = vecs[v].gnt_rand; gnt_budget = -1; lat = vecs[v].lat;
      occ = 0; max_occ = 0;
      start_burst(vecs[v].addr, vecs[v].len, vecs[v].id);
      wait_done(400, "vec_done");
      check("vec_beats", 32'(n_pops), 32'(vecs[v].beats));
      check("vec_first_add", first_add, vecs[v].first);
      check("vec_last_add", last_add, vecs[v].last);
      check("vec_occ_le_depth", 32'(max_occ <= 4), 32'h1);
      check("vec_ready_after", 32'(rd_req_ready_o), 32'h1);
    end
    check_perf("table_perf");

    // Clear after 3 grants with 2 responses still in flight.
    rdy_mode = 1; gnt_rand = 1'b0; lat = 1; hold_rsp = 1'b0; gnt_budget = 1;
    start_burst(32'h0000_3000, 4'd7, 8'h33);
    wait_grants(1, 50, "clr_grant1");
    cycle(); cycle();
    check("clr_pre_valid", 32'(rd_rsp_valid_o), 32'h1);
    hold_rsp = 1'b1; gnt_budget = 2;
    wait_grants(3, 50, "clr_grant3");
    cycle();
    clear_pulse = 1'b1;
    cycle();
    cycle();
    check("clr_valid_dropped", 32'(rd_rsp_valid_o), 32'h0);
    check("clr_ready_low", 32'(rd_req_ready_o), 32'h0);
    check("clr_busy", 32'(busy_o), 32'h1);
    check_perf("clr_perf_zero");
    hold_rsp = 1'b0;
    cycle();
    cycle();
    check("clr_ready_low_one_left", 32'(rd_req_ready_o), 32'h0);
    cycle();
    check("clr_ready_back", 32'(rd_req_ready_o), 32'h1);
    check("clr_no_stale_valid", 32'(rd_rsp_valid_o), 32'h0);
    rdy_mode = 0; gnt_budget = -1;
    start_burst(32'h0000_3100, 4'd1, 8'h34);
    wait_done(100, "clr_next_done");
    check("clr_next_beats", 32'(n_pops), 32'd2);

    // Async reset while in DRAIN with data buffered.
    rdy_mode = 1; gnt_budget = -1;
    start_burst(32'h0000_5000, 4'd3, 8'h42);
    wait_grants(4, 50, "rst_grants");
    cycle();
    check("rst_pre_busy", 32'(busy_o), 32'h1);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_req_ready", 32'(rd_req_ready_o), 32'h0);
    check("arst_tcdm_req", 32'(tcdm_req_o), 32'h0);
    check("arst_tcdm_add", tcdm_add_o, 32'h0);
    check("arst_rsp_valid", 32'(rd_rsp_valid_o), 32'h0);
    check("arst_rsp_data", rd_rsp_data_o, 32'h0);
    check("arst_rsp_last", 32'(rd_rsp_last_o), 32'h0);
    check("arst_rsp_id", 32'(rd_rsp_id_o), 32'h0);
    check("arst_busy", 32'(busy_o), 32'h0);
    check("arst_perf", perf_stall_cnt_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    rq.delete(); exp_q.delete(); addr_q.delete();
    req_pending = 1'b0; stall_cnt = '0; tcdm_r_valid_i = 1'b0; rd_req_valid_i = 1'b0;
    #1;
    check("arst_release_ready", 32'(rd_req_ready_o), 32'h1);
    rdy_mode = 0;
    start_burst(32'h0000_6000, 4'd0, 8'h99);
    wait_done(50, "arst_next_done");
    check("arst_next_beats", 32'(n_pops), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nvdla_dbb_rd_bridge.md
Name: nvdla_dbb_rd_bridge

Overview:
- Read-side bridge between the NVDLA DBB read channel and the HWPE TCDM master port.
- Sits directly downstream of the DBB request/response control structures (read request with addr/len/id; read data with data/last/id).
- Takes one DBB read burst at a time, issues one TCDM word read per beat, and buffers the non-stallable TCDM responses in a small FIFO.
- Returns the beats to NVDLA with id and last.

Parameters:
- RSP_FIFO_DEPTH, 4, response FIFO entries; power of two, >=2; also the cap on in-flight plus buffered beats.
- ID_WIDTH, 8, DBB transaction id width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous soft clear from the HWPE controller
- rd_req_valid_i  in  1  DBB read request valid
- rd_req_ready_o  out  1  DBB read request ready
- rd_req_addr_i  in  32  burst byte address
- rd_req_len_i  in  4  beats minus one (0..15 -> 1..16 beats)
- rd_req_id_i  in  ID_WIDTH  transaction id
- tcdm_req_o  out  1  TCDM request
- tcdm_gnt_i  in  1  TCDM grant
- tcdm_add_o  out  32  TCDM word address
- tcdm_r_valid_i  in  1  TCDM read response valid (in order, no backpressure)
- tcdm_r_data_i  in  32  TCDM read data
- rd_rsp_valid_o  out  1  DBB read data valid
- rd_rsp_ready_i  in  1  DBB read data ready
- rd_rsp_data_o  out  32  read data
- rd_rsp_last_o  out  1  final beat of burst
- rd_rsp_id_o  out  ID_WIDTH  id of the current burst
- busy_o  out  1  FSM not IDLE, or outstanding TCDM reads nonzero
- perf_stall_cnt_o  out  32  back-pressure cycle counter (optional feature)

Behaviour:
- Reset (rst_i=1, async): FSM=IDLE; all counters, FIFO pointers and registers cleared; every output 0.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - rd_req_ready_o=1 iff outstanding==0.
  - On valid&ready: latch addr with bits[1:0] forced to 0, latch len and id; reset issue_cnt and pop_cnt to 0; go to ISSUE next cycle.
  - Request-to-first-tcdm_req latency: 1 cycle.
- ISSUE:
  - tcdm_req_o = (credits>0).
  - tcdm_add_o = base + 4*issue_cnt, modulo 2^32; wrap allowed, no error.
  - On req&gnt: issue_cnt++, outstanding++.
  - Grant of beat len: go to DRAIN.
  - tcdm_req_o/tcdm_add_o stay stable until granted.
- Credits: credits = RSP_FIFO_DEPTH - fifo_count - outstanding. Never issue when credits==0, so the FIFO cannot overflow (assertion: tcdm_r_valid_i with FIFO full never occurs).
- TCDM response: r_valid pushes r_data into the FIFO and decrements outstanding. Grant and r_valid in the same cycle leave outstanding unchanged.
- Output side:
  - rd_rsp_valid_o = FIFO non-empty, with data from the FIFO head.
  - First-word-fall-through: the earliest valid is 1 cycle after r_valid.
  - rd_rsp_id_o = latched id; rd_rsp_last_o = (pop_cnt==len).
  - On valid&ready: pop, pop_cnt++.
  - Push and pop in the same cycle keep the count unchanged.
- DRAIN: tcdm_req_o=0; on the last-beat handshake go to IDLE. A new request can be accepted the cycle after the last beat.
- Single-beat burst (len=0): ISSUE grant goes straight to DRAIN; last=1 on the only beat.
- clear_i (sync, lower priority than rst_i):
  - FSM->IDLE; FIFO flushed; issue_cnt and pop_cnt zeroed; perf counter zeroed.
  - outstanding is NOT cleared. TCDM responses arriving while discarding (outstanding>0 after clear) decrement outstanding and are dropped, not pushed.
  - rd_req_ready_o stays low until outstanding==0.
- A request presented while busy is held off by rd_req_ready_o=0, never dropped.

Optional Feature:
- Macro: NVDLA_DBB_RD_PERF_EN.
- Defined: perf_stall_cnt_o increments on each cycle with rd_rsp_valid_o=1 and rd_rsp_ready_i=0. It saturates at 0xFFFFFFFF, is cleared by reset and clear_i, and holds its value across bursts.
- Undefined: counter logic absent; perf_stall_cnt_o tied to 0. The port is kept for interface stability.

Test Plan:
- Single beat: addr=0x1000, len=0, id=0x5A; gnt immediate, r_valid next cycle, rsp_ready=1 -> one tcdm_add=0x1000; rsp data=mem[0x1000], last=1, id=0x5A; busy_o falls after the handshake.
- Full burst with back-pressure: addr=0x2000, len=15, rsp_ready=0 throughout -> exactly 4 grants (RSP_FIFO_DEPTH); tcdm_req_o then low. Release ready -> 16 beats in address order 0x2000..0x203C; last only on beat 16; with PERF_EN, stall count equals the ready-low cycles.
- Misaligned/wrap: addr=0xFFFFFFFE, len=2 -> addresses 0xFFFFFFFC, 0x00000000, 0x00000004; data order preserved.
- Simultaneous events: gnt and r_valid every cycle with rsp_ready toggling 1/0 -> no FIFO overflow, outstanding+fifo_count<=4 at all times; all 8 beats of len=7 delivered in order.
- clear_i mid-burst: len=7, pulse clear after 3 grants with 2 responses pending -> rd_rsp_valid_o=0 immediately; pending responses dropped; rd_req_ready_o low until both return; next burst returns only its own data.
- Async reset mid-DRAIN: assert rst_i between clock edges -> all outputs 0 without waiting for a clock edge; after release, rd_req_ready_o=1 and a new len=0 request completes normally.
